cpu_reset_sequencer: RTL
========================

# cpu_reset_sequencer

Reset sequencer that sits between the board reset sources and the `soc_system` HPS platform on one side and the stack-CPU core on the other. It:
- generates the platform reset that drives `soc_system`'s `reset_reset_n`;
- consumes the HPS `h2f` reset that `soc_system` returns;
- releases the stack core's reset only after the HPS side has come out of reset and a settle delay has elapsed;
- turns a debounced push-button into a warm reset of the whole chain.

## Interface
Parameters:
- `POR_CYCLES`, 1024: cycles the platform reset is held after entering ASSERT (≥2).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before the button level is accepted (≥2).
- `CORE_DELAY_CYCLES`, 256: settle cycles between HPS reset release and core reset release (≥1).
- `HPS_TIMEOUT_CYCLES`, 16777216: maximum cycles to wait in SOC_WAIT for the HPS reset to release (≥2).

Ports:
- `clk_clk` in 1: single clock; all state is in this domain.
- `reset_reset_n` in 1: asynchronous, active-low cold reset.
- `key_n` in 1: asynchronous push-button, active-low, raw (bouncing).
- `hps_h2f_reset_n` in 1: asynchronous, active-low; driven by `soc_system` `hps_0_h2f_reset_reset_n`.
- `soc_reset_n` out 1: to `soc_system` `reset_reset_n`; active-low.
- `core_reset_n` out 1: to the stack-CPU core; active-low.
- `state` out 2: current FSM state (0 ASSERT, 1 SOC_WAIT, 2 CORE_DELAY, 3 RUN).
- `hps_timeout` out 1: sticky fault flag; cleared only by `reset_reset_n`.
- `reset_count` out 8: number of button-initiated warm resets; saturates at 255.

## Operation
**Input synchronisation**
- `key_n` and `hps_h2f_reset_n` each pass through a 2-flop synchroniser.
- `key_n` synchroniser flops reset to 1; `hps_h2f_reset_n` synchroniser flops reset to 0.

**Debounce**
- `key_db` resets to 1 (released).
- `key_db` takes the synchronised value once that value has differed from `key_db` for `DEBOUNCE_CYCLES` consecutive cycles.
- Any bounce back to the current `key_db` value restarts the count.
- `key_press` is a one-cycle pulse on each 1→0 transition of `key_db`.

**FSM states, one shared cycle counter**
- **ASSERT:** `soc_reset_n`=0, `core_reset_n`=0. The counter advances only while `key_db`=1. Go to SOC_WAIT when the counter reaches `POR_CYCLES`-1.
- **SOC_WAIT:** `soc_reset_n`=1, `core_reset_n`=0.
  - If synchronised HPS reset is 1: go to CORE_DELAY.
  - Else if the counter reaches `HPS_TIMEOUT_CYCLES`-1: set `hps_timeout`=1 and go to ASSERT.
- **CORE_DELAY:** `soc_reset_n`=1, `core_reset_n`=0.
  - If synchronised HPS reset is 0: go to SOC_WAIT.
  - Else when the counter reaches `CORE_DELAY_CYCLES`-1: go to RUN.
- **RUN:** `soc_reset_n`=1, `core_reset_n`=1. If synchronised HPS reset is 0: go to SOC_WAIT (core reset re-asserts; the platform stays out of reset).

**Counter and priority rules**
- The counter clears on every state change.
- `key_press` in SOC_WAIT, CORE_DELAY or RUN: go to ASSERT and increment `reset_count` (saturating at 255).
- `key_press` while in ASSERT restarts the counter and does not increment `reset_count`.
- Priority per cycle: `key_press` > HPS-reset transition > timeout > counter expiry.
- `hps_timeout` never blocks sequencing; retries continue indefinitely.
- Counter width is `$clog2` of the largest count parameter. No arithmetic overflow is possible because the counter clears at its terminal value.

## Timing
**Reset values (while `reset_reset_n`=0)**
- `state`=0.
- `soc_reset_n`=0, `core_reset_n`=0.
- `hps_timeout`=0, `reset_count`=0.
- Counter=0, `key_db`=1.

**Output registers**
- `soc_reset_n`, `core_reset_n` and `state` are registered.
- They are loaded from the next-state value, so each changes on the same edge as the state transition.
- Outputs are glitch-free: no combinational decode.

**Latencies**
- `reset_reset_n` release → `soc_reset_n` rises after `POR_CYCLES` rising edges (edge 1 is the first edge with reset deasserted).
- `hps_h2f_reset_n` change (setup met) → state reacts on the 3rd edge: 2 synchroniser edges + 1 FSM edge.
- SOC_WAIT→CORE_DELAY edge → `core_reset_n` rises `CORE_DELAY_CYCLES` edges later.
- HPS reset drop in RUN → `core_reset_n`=0 on the 3rd edge after the drop.
- Raw key press (clean) → `key_press` after 2 + `DEBOUNCE_CYCLES` edges; state reaches ASSERT on the next edge.

**Asynchronous cold reset**
- Asserting `reset_reset_n` mid-sequence forces the reset values immediately, without waiting for a clock.
- Deassertion is taken synchronously on the next edge.

## Test plan
All scenarios use `POR_CYCLES`=8, `DEBOUNCE_CYCLES`=4, `CORE_DELAY_CYCLES`=5, `HPS_TIMEOUT_CYCLES`=32.
1. **Cold boot:** release `reset_reset_n`; `hps_h2f_reset_n` rises 10 cycles after `soc_reset_n`. Required: `soc_reset_n` 1 at edge 8; state 2 three edges after the HPS rise; `core_reset_n` 1 five edges later; state=3.
2. **HPS drop in RUN:** pulse `hps_h2f_reset_n` low for 6 cycles. Required: `core_reset_n`=0 on the 3rd edge; `soc_reset_n` stays 1; RUN is re-entered after the HPS reset releases plus 3 + 5 edges.
3. **Bouncing key in RUN:** key pattern 0,1,0,0,1,0,0,0,0, then 0 held for 3 cycles, then released. Required:
   - exactly one `key_press`, occurring only after 4 stable low cycles;
   - state=0, `reset_count`=1, both resets 0;
   - `soc_reset_n` rises 8 edges after `key_db` returns to 1.
4. **HPS never releases:** hold `hps_h2f_reset_n`=0. Required: after 32 cycles in SOC_WAIT, `hps_timeout`=1 and state=0; the sequence repeats with `hps_timeout` still 1.
5. **Simultaneous events:** in CORE_DELAY, `key_press` and HPS drop land on the same cycle. Required: ASSERT wins; `reset_count` increments by exactly 1.
6. **Mid-sequence cold reset / saturation:**
   - Assert `reset_reset_n` in CORE_DELAY. Required: all outputs at reset values with no clock edge.
   - Apply 260 warm resets. Required: `reset_count`=255.

Source files
------------

// File: rtl/cpu_reset_sequencer.sv
// Reset sequencer: board cold reset and debounced push-button -> soc_system platform reset,
// then HPS h2f reset release -> settle delay -> stack-CPU core reset release.
//
// state      | meaning
// ASSERT     | platform and core held in reset; POR hold timer runs while button is released
// SOC_WAIT   | platform released; waiting for the HPS h2f reset to release (with timeout)
// CORE_DELAY | HPS out of reset; settle timer runs before releasing the core
// RUN        | everything out of reset
module cpu_reset_sequencer #(
  parameter int POR_CYCLES         = 1024,
  parameter int DEBOUNCE_CYCLES    = 50000,
  parameter int CORE_DELAY_CYCLES  = 256,
  parameter int HPS_TIMEOUT_CYCLES = 16777216
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       key_n,
  input  logic       hps_h2f_reset_n,
  output logic       soc_reset_n,
  output logic       core_reset_n,
  output logic [1:0] state,
  output logic       hps_timeout,
  output logic [7:0] reset_count
);

  localparam int MAX_A   = (POR_CYCLES > CORE_DELAY_CYCLES) ? POR_CYCLES : CORE_DELAY_CYCLES;
  localparam int MAX_CNT = (MAX_A > HPS_TIMEOUT_CYCLES) ? MAX_A : HPS_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(CORE_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(HPS_TIMEOUT_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT     = 2'd0,
    ST_SOC_WAIT   = 2'd1,
    ST_CORE_DELAY = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  logic            key_s1, key_s2, hps_s1, hps_s2;
  logic            key_db, key_press;
  logic [DB_W-1:0] db_cnt;

  state_t          st, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic            cnt_clr, cnt_hold, set_to, warm;

  // HPS sync resets to 0 so the core never sees a stale "released" HPS after a cold reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      hps_s1 <= 1'b0;
      hps_s2 <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      hps_s1 <= hps_h2f_reset_n;
      hps_s2 <= hps_s1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_db    <= 1'b1;
      db_cnt    <= '0;
      key_press <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        key_db    <= key_s2;
        key_press <= ~key_s2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_comb begin
    st_nxt   = st;
    cnt_clr  = 1'b0;
    cnt_hold = 1'b0;
    set_to   = 1'b0;
    warm     = 1'b0;
    case (st)
      ST_ASSERT: begin
        if (key_press)               cnt_clr = 1'b1;
        else if (!key_db)            cnt_hold = 1'b1;
        else if (cnt == POR_LAST)    st_nxt = ST_SOC_WAIT;
      end
      ST_SOC_WAIT: begin
        if (key_press) begin
          st_nxt = ST_ASSERT;
          warm   = 1'b1;
        end else if (hps_s2) begin
          st_nxt = ST_CORE_DELAY;
        end else if (cnt == TO_LAST) begin
          st_nxt = ST_ASSERT;
          set_to = 1'b1;
        end
      end
      ST_CORE_DELAY: begin
        if (key_press) begin
          st_nxt = ST_ASSERT;
          warm   = 1'b1;
        end else if (!hps_s2) begin
          st_nxt = ST_SOC_WAIT;
        end else if (cnt == CD_LAST) begin
          st_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_hold = 1'b1;
        if (key_press) begin
          st_nxt = ST_ASSERT;
          warm   = 1'b1;
        end else if (!hps_s2) begin
          st_nxt = ST_SOC_WAIT;
        end
      end
      default: st_nxt = ST_ASSERT;
    endcase
  end

  // Outputs are decoded from st_nxt so they move on the same edge as the state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      st           <= ST_ASSERT;
      cnt          <= '0;
      soc_reset_n  <= 1'b0;
      core_reset_n <= 1'b0;
      hps_timeout  <= 1'b0;
      reset_count  <= 8'd0;
    end else begin
      st           <= st_nxt;
      soc_reset_n  <= (st_nxt != ST_ASSERT);
      core_reset_n <= (st_nxt == ST_RUN);
      if ((st_nxt != st) || cnt_clr) cnt <= '0;
      else if (!cnt_hold)             cnt <= cnt + CNT_W'(1);
      if (set_to) hps_timeout <= 1'b1;
      if (warm && (reset_count != 8'hFF)) reset_count <= reset_count + 8'd1;
    end
  end

  assign state = st;

endmodule
